joy_answer_arbiter: RTL and testbench

//   Front end for the two-player quiz: conditions both raw active-low 4-way joysticks.

---
 rtl/joy_pkg.sv | 32 +++
 rtl/joy_debounce.sv | 58 +++++
 rtl/joy_answer_arbiter.sv | 118 +++++++++++
 tb/tb_joy_answer_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared constants, state encoding and pattern encoder for the joystick
// answer arbiter and its per-player debounce front end.
package joy_pkg;

   localparam logic [2:0] JOY_NONE = 3'd0;
   localparam logic [2:0] JOY_1    = 3'd1;
   localparam logic [2:0] JOY_2    = 3'd2;
   localparam logic [2:0] JOY_3    = 3'd3;
   localparam logic [2:0] JOY_4    = 3'd4;

   localparam logic PLAYER_L = 1'b0;
   localparam logic PLAYER_R = 1'b1;

   typedef enum logic {
      ARMED  = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Exactly one active-low key maps to a direction; anything else is "none".
   function automatic logic [2:0] joy_encode(input logic [3:0] pat);
      logic [2:0] c;
      case (pat)
         4'b1110: c = JOY_1;
         4'b1101: c = JOY_2;
         4'b1011: c = JOY_3;
         4'b0111: c = JOY_4;
         default: c = JOY_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/joy_debounce.sv
// One joystick: 2-flop synchroniser, stability debounce, direction encode and
// a single-cycle press event on a 0 -> nonzero code transition.
module joy_debounce
   import joy_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] joy_n,
   output logic [2:0] code,
   output logic       press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       prev;
   logic [3:0]       stable;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       code_d;

   // Synchronise, count consecutive unchanged samples, accept pattern once stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '1;
         sync2  <= '1;
         prev   <= '1;
         stable <= '1;
         cnt    <= '0;
         code_d <= JOY_NONE;
      end else begin
         sync1  <= joy_n;
         sync2  <= sync1;
         prev   <= sync2;
         code_d <= code;
         if (sync2 != prev) begin
            cnt <= '0;
         end else begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_W'(1);
            end
            if (cnt == CNT_MAX) begin
               stable <= sync2;
            end
         end
      end
   end

   // Code follows the accepted pattern; a press is only a release-to-key edge.
   always_comb begin
      code  = joy_encode(stable);
      press = (code != JOY_NONE) && (code_d == JOY_NONE);
   end

endmodule

// File: rtl/joy_answer_arbiter.sv
// Two-player answer arbiter: first press wins, then locked until round_clr.
// Optional macro JOY_TIE_ROUND_ROBIN_EN alternates tie winner (left first);
// without it left always wins ties.
module joy_answer_arbiter
   import joy_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] joy_l_n,
   input  logic [3:0] joy_r_n,
   input  logic       round_clr,
   output logic [2:0] joy_l_code,
   output logic [2:0] joy_r_code,
   output logic       ans_valid,
   output logic       ans_player,
   output logic [2:0] ans_code,
   output logic       locked
);

   logic       press_l;
   logic       press_r;
   arb_state_t state;
   arb_state_t state_nxt;
   logic       accept;
   logic       acc_player;
   logic [2:0] acc_code;
`ifdef JOY_TIE_ROUND_ROBIN_EN
   logic       ptr;
   logic       ptr_nxt;
`endif

   joy_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb_l (
      .clk  (clk),
      .rst_n(rst_n),
      .joy_n(joy_l_n),
      .code (joy_l_code),
      .press(press_l)
   );

   joy_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb_r (
      .clk  (clk),
      .rst_n(rst_n),
      .joy_n(joy_r_n),
      .code (joy_r_code),
      .press(press_r)
   );

   // Next state and accept decision; round_clr overrides any coincident press.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      acc_player = PLAYER_L;
      acc_code   = JOY_NONE;
`ifdef JOY_TIE_ROUND_ROBIN_EN
      ptr_nxt    = ptr;
`endif
      if (round_clr) begin
         state_nxt = ARMED;
      end else if (state == ARMED && (press_l || press_r)) begin
         accept    = 1'b1;
         state_nxt = LOCKED;
         if (press_l && press_r) begin
`ifdef JOY_TIE_ROUND_ROBIN_EN
            acc_player = ptr;
            ptr_nxt    = ~ptr;
`else
            acc_player = PLAYER_L;
`endif
         end else begin
            acc_player = press_r ? PLAYER_R : PLAYER_L;
         end
         acc_code = (acc_player == PLAYER_R) ? joy_r_code : joy_l_code;
      end
   end

   // State and answer output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARMED;
         ans_valid  <= 1'b0;
         ans_player <= PLAYER_L;
         ans_code   <= JOY_NONE;
      end else begin
         state     <= state_nxt;
         ans_valid <= accept;
         if (accept) begin
            ans_player <= acc_player;
            ans_code   <= acc_code;
         end
      end
   end

`ifdef JOY_TIE_ROUND_ROBIN_EN
   // Tie pointer, advanced only by ties actually resolved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PLAYER_L;
      end else begin
         ptr <= ptr_nxt;
      end
   end
`endif

   // Locked whenever an answer has been taken this round.
   always_comb begin
      locked = (state == LOCKED);
   end

endmodule

// File: tb/tb_joy_answer_arbiter.sv
// Directed bench for joy_answer_arbiter with DEBOUNCE_CYCLES=4.
module tb_joy_answer_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] joy_l_n;
   logic [3:0] joy_r_n;
   logic       round_clr;
   logic [2:0] joy_l_code;
   logic [2:0] joy_r_code;
   logic       ans_valid;
   logic       ans_player;
   logic [2:0] ans_code;
   logic       locked;

   int checks   = 0;
   int failures = 0;
   int vcount   = 0;
   logic prev_av = 1'b0;

   joy_answer_arbiter #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .joy_l_n   (joy_l_n),
      .joy_r_n   (joy_r_n),
      .round_clr (round_clr),
      .joy_l_code(joy_l_code),
      .joy_r_code(joy_r_code),
      .ans_valid (ans_valid),
      .ans_player(ans_player),
      .ans_code  (ans_code),
      .locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count accepted answers and flag back-to-back pulses.
   always @(negedge clk) begin
      if (rst_n && ans_valid === 1'b1) begin
         vcount++;
         checks++;
         if (prev_av !== 1'b0) begin
            failures++;
            $display("FAIL av_consecutive got=%b exp=0", prev_av);
         end
      end
      prev_av = rst_n ? ans_valid : 1'b0;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      round_clr = 1'b1;
      step(1);
      round_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; joy_l_n = 4'b1111; joy_r_n = 4'b1111; round_clr = 1'b0;
      step(2);
      checks++; if (ans_valid !== 1'b0) begin failures++; $display("FAIL rst_av got=%b exp=0", ans_valid); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
      checks++; if (ans_code !== 3'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", ans_code); end
      checks++; if (joy_l_code !== 3'd0) begin failures++; $display("FAIL rst_lcode got=%0d exp=0", joy_l_code); end
      rst_n = 1'b1;
      step(10);
      checks++; if (vcount !== 0) begin failures++; $display("FAIL rst_noevent got=%0d exp=0", vcount); end
   endtask

   task automatic test_single_press();
      int v0 = vcount;
      joy_l_n = 4'b1110;
      step(6);
      checks++; if (joy_l_code !== 3'd0) begin failures++; $display("FAIL t1_early got=%0d exp=0", joy_l_code); end
      step(1);
      checks++; if (joy_l_code !== 3'd1) begin failures++; $display("FAIL t1_lcode got=%0d exp=1", joy_l_code); end
      checks++; if (ans_valid !== 1'b0) begin failures++; $display("FAIL t1_av_early got=%b exp=0", ans_valid); end
      step(1);
      checks++; if (ans_valid !== 1'b1) begin failures++; $display("FAIL t1_av got=%b exp=1", ans_valid); end
      checks++; if (ans_player !== 1'b0) begin failures++; $display("FAIL t1_player got=%b exp=0", ans_player); end
      checks++; if (ans_code !== 3'd1) begin failures++; $display("FAIL t1_code got=%0d exp=1", ans_code); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL t1_locked got=%b exp=1", locked); end
      step(5);
      checks++; if (vcount - v0 !== 1) begin failures++; $display("FAIL t1_count got=%0d exp=1", vcount - v0); end
      joy_l_n = 4'b1111;
      step(8);
      pulse_clr();
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t1_rearm got=%b exp=0", locked); end
   endtask

   task automatic test_bounce();
      int v0 = vcount;
      for (int i = 0; i < 6; i++) begin
         joy_r_n = (i % 2 == 0) ? 4'b1011 : 4'b1111;
         step(2);
      end
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t2_bounce_ev got=%0d exp=%0d", vcount, v0); end
      checks++; if (joy_r_code !== 3'd0) begin failures++; $display("FAIL t2_bounce_code got=%0d exp=0", joy_r_code); end
      joy_r_n = 4'b1011;
      step(7);
      checks++; if (joy_r_code !== 3'd3) begin failures++; $display("FAIL t2_rcode got=%0d exp=3", joy_r_code); end
      step(1);
      checks++; if (ans_valid !== 1'b1) begin failures++; $display("FAIL t2_av got=%b exp=1", ans_valid); end
      checks++; if (ans_player !== 1'b1) begin failures++; $display("FAIL t2_player got=%b exp=1", ans_player); end
      checks++; if (ans_code !== 3'd3) begin failures++; $display("FAIL t2_code got=%0d exp=3", ans_code); end
      step(4);
      checks++; if (vcount - v0 !== 1) begin failures++; $display("FAIL t2_count got=%0d exp=1", vcount - v0); end
   endtask

   task automatic test_locked_drop();
      int v0 = vcount;
      joy_r_n = 4'b1111; joy_l_n = 4'b0111;
      step(10);
      checks++; if (joy_l_code !== 3'd4) begin failures++; $display("FAIL t3_lcode got=%0d exp=4", joy_l_code); end
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t3_dropped got=%0d exp=%0d", vcount, v0); end
      checks++; if (ans_code !== 3'd3) begin failures++; $display("FAIL t3_hold_code got=%0d exp=3", ans_code); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL t3_locked got=%b exp=1", locked); end
      joy_l_n = 4'b1111;
      step(8);
      pulse_clr();
      joy_r_n = 4'b1101;
      step(8);
      checks++; if (ans_valid !== 1'b1) begin failures++; $display("FAIL t3_av got=%b exp=1", ans_valid); end
      checks++; if (ans_player !== 1'b1) begin failures++; $display("FAIL t3_player got=%b exp=1", ans_player); end
      checks++; if (ans_code !== 3'd2) begin failures++; $display("FAIL t3_code got=%0d exp=2", ans_code); end
      joy_r_n = 4'b1111;
      step(8);
      pulse_clr();
   endtask

   task automatic test_tie();
      logic [2:0] exp_player;
`ifdef JOY_TIE_ROUND_ROBIN_EN
      exp_player = 3'b010;
`else
      exp_player = 3'b000;
`endif
      for (int r = 0; r < 3; r++) begin
         joy_l_n = 4'b1110; joy_r_n = 4'b0111;
         step(8);
         checks++; if (ans_valid !== 1'b1) begin failures++; $display("FAIL t4_av r%0d got=%b exp=1", r, ans_valid); end
         checks++; if (ans_player !== exp_player[r]) begin failures++; $display("FAIL t4_player r%0d got=%b exp=%b", r, ans_player, exp_player[r]); end
         checks++; if (ans_code !== (exp_player[r] ? 3'd4 : 3'd1)) begin failures++; $display("FAIL t4_code r%0d got=%0d exp=%0d", r, ans_code, exp_player[r] ? 4 : 1); end
         step(1);
         checks++; if (ans_valid !== 1'b0) begin failures++; $display("FAIL t4_single r%0d got=%b exp=0", r, ans_valid); end
         joy_l_n = 4'b1111; joy_r_n = 4'b1111;
         step(8);
         pulse_clr();
      end
   endtask

   task automatic test_hold_across_clr();
      int v0;
      joy_l_n = 4'b1110;
      step(8);
      checks++; if (ans_valid !== 1'b1) begin failures++; $display("FAIL t5_first got=%b exp=1", ans_valid); end
      step(2);
      pulse_clr();
      v0 = vcount;
      step(10);
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t5_held got=%0d exp=%0d", vcount, v0); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t5_armed got=%b exp=0", locked); end
      joy_l_n = 4'b1111;
      step(8);
      joy_l_n = 4'b1110;
      step(8);
      checks++; if (ans_valid !== 1'b1) begin failures++; $display("FAIL t5_repress got=%b exp=1", ans_valid); end
      checks++; if (ans_player !== 1'b0) begin failures++; $display("FAIL t5_player got=%b exp=0", ans_player); end
      pulse_clr();
      v0 = vcount;
      joy_l_n = 4'b1101;
      step(10);
      checks++; if (joy_l_code !== 3'd2) begin failures++; $display("FAIL t5_slide_code got=%0d exp=2", joy_l_code); end
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t5_slide got=%0d exp=%0d", vcount, v0); end
      joy_l_n = 4'b1111;
      step(8);
   endtask

   task automatic test_misc();
      int v0 = vcount;
      joy_l_n = 4'b1100;
      step(10);
      checks++; if (joy_l_code !== 3'd0) begin failures++; $display("FAIL t6_multi_code got=%0d exp=0", joy_l_code); end
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t6_multi_ev got=%0d exp=%0d", vcount, v0); end
      joy_l_n = 4'b1111;
      step(8);
      joy_r_n = 4'b1101;
      step(7);
      checks++; if (joy_r_code !== 3'd2) begin failures++; $display("FAIL t6_pre_code got=%0d exp=2", joy_r_code); end
      round_clr = 1'b1;
      step(1);
      round_clr = 1'b0;
      checks++; if (ans_valid !== 1'b0) begin failures++; $display("FAIL t6_clr_av got=%b exp=0", ans_valid); end
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t6_clr_locked got=%b exp=0", locked); end
      step(5);
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t6_clr_ev got=%0d exp=%0d", vcount, v0); end
      joy_r_n = 4'b1111;
      step(8);
      joy_l_n = 4'b1110;
      step(8);
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL t6_prelock got=%b exp=1", locked); end
      joy_r_n = 4'b1011;
      step(3);
      v0 = vcount;
      rst_n = 1'b0;
      #1;
      checks++; if (locked !== 1'b0) begin failures++; $display("FAIL t6_rst_locked got=%b exp=0", locked); end
      checks++; if (ans_code !== 3'd0) begin failures++; $display("FAIL t6_rst_code got=%0d exp=0", ans_code); end
      checks++; if (joy_l_code !== 3'd0) begin failures++; $display("FAIL t6_rst_lcode got=%0d exp=0", joy_l_code); end
      checks++; if (ans_valid !== 1'b0) begin failures++; $display("FAIL t6_rst_av got=%b exp=0", ans_valid); end
      joy_l_n = 4'b1111; joy_r_n = 4'b1111;
      step(2);
      rst_n = 1'b1;
      step(12);
      checks++; if (vcount !== v0) begin failures++; $display("FAIL t6_rst_release got=%0d exp=%0d", vcount, v0); end
      checks++; if (joy_r_code !== 3'd0) begin failures++; $display("FAIL t6_rst_rcode got=%0d exp=0", joy_r_code); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_locked_drop();
      test_tie();
      test_hold_across_clr();
      test_misc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
